// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between an instruction-fetch port and a data port.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants under contention; default gives data fixed priority.
//
// state  | meaning
// IDLE   | wait for a request; latch grant, word address, we and wdata
// ACCESS | drive exactly one memory read or write strobe
// RESP   | mem_read_val valid; ack and rdata registered at the closing edge
module mem_port_arbiter #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 256,
  localparam int ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req,
  input  logic [31:0]          i_addr,
  output logic                 i_ack,
  output logic [MEM_WIDTH-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [31:0]          d_addr,
  input  logic [MEM_WIDTH-1:0] d_wdata,
  output logic                 d_ack,
  output logic [MEM_WIDTH-1:0] d_rdata,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [MEM_WIDTH-1:0] mem_write_val,
  input  logic [MEM_WIDTH-1:0] mem_read_val
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t               state_q, state_d;
  logic                 gnt_d_q, gnt_d_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [MEM_WIDTH-1:0] wdata_q, wdata_d;
  logic                 i_ack_q, i_ack_d;
  logic                 d_ack_q, d_ack_d;
  logic [MEM_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [MEM_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                 sel_d;
  logic                 grant_now;

  // Byte-offset and out-of-range address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], i_addr[31:ADDR_W+2], d_addr[1:0], d_addr[31:ADDR_W+2]};

  assign grant_now = (state_q == IDLE) && (i_req || d_req);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic prefer_d_q, prefer_d_d;

  assign sel_d = d_req && (!i_req || prefer_d_q);

  always_comb begin
    prefer_d_d = prefer_d_q;
    if (grant_now) prefer_d_d = !sel_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) prefer_d_q <= 1'b0;
    else        prefer_d_q <= prefer_d_d;
  end
`else
  assign sel_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_req || d_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d_d   = gnt_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (grant_now) begin
      gnt_d_d = sel_d;
      if (sel_d) begin
        we_d    = d_we;
        addr_d  = d_addr[ADDR_W+1:2];
        wdata_d = d_wdata;
      end else begin
        we_d    = 1'b0;
        addr_d  = i_addr[ADDR_W+1:2];
      end
    end
    if (state_q == RESP) begin
      if (gnt_d_q) begin
        d_ack_d = 1'b1;
        if (!we_q) d_rdata_d = mem_read_val;
      end else begin
        i_ack_d   = 1'b1;
        i_rdata_d = mem_read_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_d_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      gnt_d_q   <= gnt_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    if (state_q == ACCESS) begin
      mem_read_en  = !we_q;
      mem_write_en = we_q;
    end
  end

  assign mem_addr      = addr_q;
  assign mem_write_val = wdata_q;
  assign i_ack         = i_ack_q;
  assign d_ack         = d_ack_q;
  assign i_rdata       = i_rdata_q;
  assign d_rdata       = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner-case sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack, d_ack;
  logic [31:0] i_rdata, d_rdata;
  logic [7:0]  mem_addr;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_write_val;
  logic [31:0] mem_read_val = 32'h0;

  logic [31:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_write_val(mem_write_val), .mem_read_val(mem_read_val)
  );

  always #5 clk = ~clk;

  // Shared memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr] <= mem_write_val;
    if (mem_read_en)  mem_read_val  <= mem[mem_addr];
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  exp_maddr;
    logic [31:0] exp_irdata;
    logic [31:0] exp_drdata;
  } vec_t;

  vec_t vt[7];

  // Reference model state
  logic [31:0] ref_mem [256];
  int          acc_t, ack_t, next_free;
  logic        m_port_d, m_we, pick_d, last_d;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_rdata, e_irdata, e_drdata, a_sel;
  logic        exp_ia, exp_da;

  // Vector-table / sequence scratch
  int          lat, n_i, n_d, first_ack;
  logic        acked, saw_rd, saw_wr, got_i, got_d;
  logic [7:0]  maddr;
  logic [31:0] wval;
  logic [1:0]  ack_seq [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    mem[1] = 32'h1111_0001;
    mem[3] = 32'h3333_0003;
    mem[4] = 32'h2008_0005;

    vt[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         8'd4, 32'h2008_0005, 32'h0};
    vt[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 8'd8, 32'h2008_0005, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         8'd8, 32'h2008_0005, 32'hDEAD_BEEF};
    vt[3] = '{1'b0, 1'b0, 32'h0000_0404, 32'h0,         8'd1, 32'h1111_0001, 32'hDEAD_BEEF};
    vt[4] = '{1'b1, 1'b0, 32'hFFFF_FC0F, 32'h0,         8'd3, 32'h1111_0001, 32'h3333_0003};
    vt[5] = '{1'b1, 1'b1, 32'h0000_0013, 32'h1234_5678, 8'd4, 32'h1111_0001, 32'h3333_0003};
    vt[6] = '{1'b0, 1'b0, 32'h0000_0012, 32'h0,         8'd4, 32'h1234_5678, 32'h3333_0003};

    reset_dut();
    chk("rst i_ack",     32'(i_ack), 32'h0);
    chk("rst d_ack",     32'(d_ack), 32'h0);
    chk("rst rd_en",     32'(mem_read_en), 32'h0);
    chk("rst wr_en",     32'(mem_write_en), 32'h0);
    chk("rst mem_addr",  32'(mem_addr), 32'h0);
    chk("rst wval",      mem_write_val, 32'h0);
    chk("rst i_rdata",   i_rdata, 32'h0);
    chk("rst d_rdata",   d_rdata, 32'h0);

    for (int i = 0; i < 7; i++) begin
      i_req = !vt[i].is_d; i_addr = vt[i].addr;
      d_req = vt[i].is_d;  d_we = vt[i].we; d_addr = vt[i].addr; d_wdata = vt[i].wdata;
      acked = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0; got_i = 1'b0; got_d = 1'b0;
      lat = 0; maddr = 8'hxx; wval = 32'hx;
      while (!acked && lat < 10) begin
        step();
        lat++;
        if (mem_read_en)  begin saw_rd = 1'b1; maddr = mem_addr; end
        if (mem_write_en) begin saw_wr = 1'b1; maddr = mem_addr; wval = mem_write_val; end
        if (i_ack || d_ack) begin
          acked = 1'b1; got_i = i_ack; got_d = d_ack;
          i_req = 1'b0; d_req = 1'b0;
        end
      end
      i_req = 1'b0; d_req = 1'b0;
      chk($sformatf("vec%0d acked", i),   32'(acked), 32'h1);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d d_ack", i),   32'(got_d), 32'(vt[i].is_d));
      chk($sformatf("vec%0d i_ack", i),   32'(got_i), 32'(!vt[i].is_d));
      chk($sformatf("vec%0d wr_en", i),   32'(saw_wr), 32'(vt[i].is_d && vt[i].we));
      chk($sformatf("vec%0d rd_en", i),   32'(saw_rd), 32'(!(vt[i].is_d && vt[i].we)));
      chk($sformatf("vec%0d mem_addr", i), 32'(maddr), 32'(vt[i].exp_maddr));
      if (saw_wr) chk($sformatf("vec%0d wval", i), wval, vt[i].wdata);
      chk($sformatf("vec%0d i_rdata", i), i_rdata, vt[i].exp_irdata);
      chk($sformatf("vec%0d d_rdata", i), d_rdata, vt[i].exp_drdata);
      step();
    end

    // Reset while a data read is in ACCESS: no ack, everything cleared.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
    step();
    chk("midrst rd_en", 32'(mem_read_en), 32'h1);
    rst_n = 1'b0; d_req = 1'b0;
    step();
    chk("midrst d_ack",    32'(d_ack), 32'h0);
    chk("midrst i_ack",    32'(i_ack), 32'h0);
    chk("midrst rd_en",    32'(mem_read_en), 32'h0);
    chk("midrst wr_en",    32'(mem_write_en), 32'h0);
    chk("midrst mem_addr", 32'(mem_addr), 32'h0);
    chk("midrst wval",     mem_write_val, 32'h0);
    chk("midrst i_rdata",  i_rdata, 32'h0);
    chk("midrst d_rdata",  d_rdata, 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post-rst d_ack", 32'(d_ack), 32'h0);
    end

    // In-flight access ignores address changes after grant.
    i_req = 1'b1; i_addr = 32'h10;
    step();
    chk("hold mem_addr", 32'(mem_addr), 32'd4);
    chk("hold rd_en",    32'(mem_read_en), 32'h1);
    i_addr = 32'h404;
    step();
    step();
    chk("hold i_ack",   32'(i_ack), 32'h1);
    chk("hold i_rdata", i_rdata, 32'h1234_5678);
    i_req = 1'b0;
    step();

    // Contention: both held for 12 cycles from a fresh reset.
    reset_dut();
    i_req = 1'b1; i_addr = 32'h04;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0C;
    n_i = 0; n_d = 0; first_ack = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (i_ack && d_ack) chk("cont both acks", 32'h1, 32'h0);
      if ((i_ack || d_ack) && (n_i + n_d) < 4) ack_seq[n_i + n_d] = i_ack ? 2'd1 : 2'd2;
      if ((i_ack || d_ack) && first_ack == 0) first_ack = k;
      if (i_ack) n_i++;
      if (d_ack) n_d++;
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("cont first ack", 32'(first_ack), 32'd3);
    chk("cont total acks", 32'(n_i + n_d), 32'd4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++)
      chk($sformatf("cont rr ack%0d", k), 32'(ack_seq[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
`else
    chk("cont d_acks", 32'(n_d), 32'd4);
    chk("cont i_acks", 32'(n_i), 32'd0);
`endif
    step();
    step();

    // Randomized traffic against the transaction-level model.
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 256; k++) begin
      mem[k] = $urandom;
      ref_mem[k] = mem[k];
    end
    step();
    step();
    rst_n = 1'b1;
    acc_t = -10; ack_t = -10; next_free = 1;
    e_irdata = 32'h0; e_drdata = 32'h0; last_d = 1'b1;
    m_port_d = 1'b0; m_we = 1'b0; m_addr = 8'h0; m_wdata = 32'h0; m_rdata = 32'h0;
    for (int t = 0; t < 2000; t++) begin
      exp_ia = (ack_t == t) && !m_port_d;
      exp_da = (ack_t == t) && m_port_d;
      if (exp_ia) e_irdata = m_rdata;
      if (exp_da && !m_we) e_drdata = m_rdata;
      chk("rnd i_ack", 32'(i_ack), 32'(exp_ia));
      chk("rnd d_ack", 32'(d_ack), 32'(exp_da));
      chk("rnd rd_en", 32'(mem_read_en),  32'((acc_t == t) && !m_we));
      chk("rnd wr_en", 32'(mem_write_en), 32'((acc_t == t) && m_we));
      if (acc_t == t) begin
        chk("rnd mem_addr", 32'(mem_addr), 32'(m_addr));
        if (m_we) chk("rnd wval", mem_write_val, m_wdata);
      end
      chk("rnd i_rdata", i_rdata, e_irdata);
      chk("rnd d_rdata", d_rdata, e_drdata);

      // Requesters hold until acked, then randomly renew or drop.
      if (exp_ia || !i_req) begin
        i_req  = 1'($urandom_range(1, 0));
        i_addr = $urandom;
      end
      if (exp_da || !d_req) begin
        d_req   = 1'($urandom_range(1, 0));
        d_we    = 1'($urandom_range(1, 0));
        d_addr  = $urandom;
        d_wdata = $urandom;
      end

      if (t + 1 >= next_free && (i_req || d_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (i_req && d_req) pick_d = !last_d;
        else                pick_d = d_req;
        last_d = pick_d;
`else
        pick_d = d_req;
`endif
        m_port_d = pick_d;
        m_we     = pick_d && d_we;
        a_sel    = pick_d ? d_addr : i_addr;
        m_addr   = 8'((a_sel / 4) % 256);
        m_wdata  = d_wdata;
        if (m_we) ref_mem[m_addr] = m_wdata;
        m_rdata  = ref_mem[m_addr];
        acc_t = t + 1; ack_t = t + 3; next_free = t + 4;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
